// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes a word stream onto the fabric config chain, or runs a marker chain test.
module ccff_chain_loader #(
  parameter int BITSTREAM_SIZE = 29647,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  chain_test,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  bit_count
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TEST, S_CHECK, S_DONE} state_t;
  localparam int SW = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] L_N  = CNT_WIDTH'(BITSTREAM_SIZE);
  localparam logic [CNT_WIDTH-1:0] L_N1 = CNT_WIDTH'(BITSTREAM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] L_T  = CNT_WIDTH'(BITSTREAM_SIZE + 4);
  localparam logic [CNT_WIDTH-1:0] L_W  = CNT_WIDTH'((BITSTREAM_SIZE + DATA_WIDTH - 1) / DATA_WIDTH);
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_sreg, r_buf;
  logic                  r_buf_full, r_head, r_shift_en, r_error;
  logic [SW-1:0]         r_sbits;
  logic [CNT_WIDTH-1:0]  r_words, r_count, w_issued;
  logic                  w_start, w_load, w_go, w_bit, w_accept, w_from_buf, w_bad;
  assign w_load     = r_state == S_LOAD;
  assign w_start    = start & (r_state == S_IDLE | r_state == S_DONE);
  assign s_ready    = w_load & !r_buf_full & (r_words < L_W);
  assign w_accept   = s_valid & s_ready;
  assign w_issued   = r_count + CNT_WIDTH'(r_shift_en);
  assign w_from_buf = r_sbits == '0;
  // Shifts already issued include the one in flight, so the total is exact without a lookahead.
  assign w_go  = (w_load & (w_issued < L_N) & (!w_from_buf | r_buf_full)) |
                 (r_state == S_TEST & (w_issued < L_T));
  assign w_bit = r_state == S_TEST ? w_issued == '0
               : (w_from_buf ? r_buf[DATA_WIDTH-1] : r_sreg[DATA_WIDTH-1]);
  assign w_bad = (r_state == S_TEST | r_state == S_CHECK) & (r_count >= L_N1) & (r_count <= L_T) &
                 (ccff_tail != (r_count == L_N));
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) r_state <= S_IDLE;
    else            r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_start ? (chain_test ? S_TEST : S_LOAD) : r_state;
      S_LOAD:         w_next = (r_shift_en & w_issued == L_N) ? S_DONE : S_LOAD;
      S_TEST:         w_next = w_issued == L_T ? S_CHECK : S_TEST;
      S_CHECK:        w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_sreg     <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_sbits    <= '0;
      r_words    <= '0;
      r_count    <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_shift_en <= w_go;
      r_head     <= w_go & w_bit;
      if (w_start) begin
        r_count    <= '0;
        r_error    <= 1'b0;
        r_words    <= '0;
        r_buf_full <= 1'b0;
        r_sbits    <= '0;
      end else begin
        r_count <= w_issued;
        r_error <= r_error | w_bad;
        if (w_accept) begin
          r_buf      <= s_data;
          r_buf_full <= 1'b1;
          r_words    <= r_words + CNT_WIDTH'(1);
        end else if (w_load & w_go & w_from_buf) r_buf_full <= 1'b0;
        if (w_load & w_go) begin
          r_sreg  <= (w_from_buf ? r_buf : r_sreg) << 1;
          r_sbits <= w_from_buf ? SW'(DATA_WIDTH - 1) : r_sbits - SW'(1);
        end
      end
    end
  end
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_state == S_LOAD | r_state == S_TEST | r_state == S_CHECK;
  assign done          = r_state == S_DONE;
  assign error         = r_error;
  assign bit_count     = r_count;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed load / chain-test / reset / restart scenarios against an N-FF chain model.
module tb_ccff_chain_loader;
  logic        prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b0, chain_test = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
  logic [15:0] bit_count;
  logic [69:0] chain = '0;
  logic [6:0]  len = 7'd70;
  logic        clr = 1'b0;
  logic [31:0] words [3] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFC000000};
  localparam logic [69:0] EXP = {32'hA5A5A5A5, 32'h0F0F0F0F, 6'b111111};
  int checks = 0, failures = 0;
  int shifts = 0, hs = 0, dones = 0, stalls = 0, frz_bad = 0;
  logic done_q = 1'b0, pstall = 1'b0;
  logic [15:0] pbc = '0;
  int b_s, b_h, b_d, b_st, cyc;
  ccff_chain_loader #(.BITSTREAM_SIZE(70), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .chain_test(chain_test),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .error(error), .bit_count(bit_count));
  always #5 prog_clk = ~prog_clk;
  assign ccff_tail = chain[len - 7'd1];
  always @(posedge prog_clk) chain <= clr ? '0 : (ccff_shift_en ? {chain[68:0], ccff_head} : chain);
  always @(negedge prog_clk) begin
    if (ccff_shift_en) shifts <= shifts + 1;
    if (s_valid & s_ready) hs <= hs + 1;
    if (done & !done_q) dones <= dones + 1;
    done_q <= done;
    if (busy & !ccff_shift_en & bit_count != '0) stalls <= stalls + 1;
    if (busy & !ccff_shift_en & bit_count != '0 & pstall & bit_count != pbc) frz_bad <= frz_bad + 1;
    pstall <= busy & !ccff_shift_en & bit_count != '0;
    pbc    <= bit_count;
  end
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge prog_clk);
    #1;
  endtask
  task automatic run(input bit test, input bit gap, input int pulse_at, input int rst_at);
    b_s = shifts; b_h = hs; b_d = dones; b_st = stalls;
    chain_test = test;
    start = 1'b1;
    step;
    start = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      int w;
      w = hs - b_h;
      s_valid = !test && w < 3 && !(gap && w == 1 && cyc < 45);
      s_data  = w < 3 ? words[w] : '0;
      start   = cyc == pulse_at;
      if (rst_at >= 0 && shifts - b_s == rst_at) begin
        prog_reset = 1'b1;
        break;
      end
      if (done) break;
      step;
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (!prog_reset) begin
      check("run_done_in_time", 96'(done), 96'd1);
      repeat (3) step;
    end
  endtask
  initial begin
    step; step;
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_done_err", 96'({done, error}), 96'd0);
    check("rst_shift", 96'({ccff_shift_en, ccff_head}), 96'd0);
    check("rst_ready_cnt", 96'({s_ready, bit_count}), 96'd0);
    prog_reset = 1'b0;
    step;
    run(1'b0, 1'b0, -1, -1);
    check("s1_chain", 96'(chain), 96'(EXP));
    check("s1_shifts", 96'(shifts - b_s), 96'd70);
    check("s1_handshakes", 96'(hs - b_h), 96'd3);
    check("s1_bit_count", 96'(bit_count), 96'd70);
    check("s1_done_busy", 96'({done, busy, ccff_shift_en}), 96'b100);
    check("s1_no_stall", 96'(stalls - b_st), 96'd0);
    clr = 1'b1; step; clr = 1'b0;
    run(1'b0, 1'b1, -1, -1);
    check("s2_stalled", 96'(stalls - b_st > 5), 96'd1);
    check("s2_frozen", 96'(frz_bad), 96'd0);
    check("s2_chain", 96'(chain), 96'(EXP));
    check("s2_shifts_hs", 96'({shifts - b_s, hs - b_h}), {32'd0, 32'd70, 32'd3});
    clr = 1'b1; step; clr = 1'b0;
    run(1'b1, 1'b0, -1, -1);
    check("s3_error", 96'(error), 96'd0);
    check("s3_bit_count", 96'(bit_count), 96'd74);
    check("s3_shifts_hs", 96'({shifts - b_s, hs - b_h}), {32'd0, 32'd74, 32'd0});
    clr = 1'b1; len = 7'd69; step; clr = 1'b0;
    run(1'b1, 1'b0, -1, -1);
    check("s4_error_done", 96'({error, done}), 96'b11);
    len = 7'd70;
    run(1'b0, 1'b0, -1, 40);
    #1;
    check("s5_rst_outputs", 96'({busy, done, error, ccff_shift_en, ccff_head, s_ready}), 96'd0);
    check("s5_rst_count", 96'(bit_count), 96'd0);
    b_s = shifts;
    step; step; step;
    check("s5_no_shift", 96'(shifts - b_s), 96'd0);
    prog_reset = 1'b0;
    step;
    run(1'b0, 1'b0, -1, -1);
    check("s5_chain", 96'(chain), 96'(EXP));
    check("s5_count_hs", 96'({bit_count, hs - b_h}), {32'd0, 32'd70, 32'd3});
    run(1'b0, 1'b0, 20, -1);
    check("s6_shifts", 96'(shifts - b_s), 96'd70);
    check("s6_dones", 96'(dones - b_d), 96'd1);
    check("s6_count_chain", {bit_count, 10'd0, chain}, {16'd70, 10'd0, EXP});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
